// File: rtl/mnist_pkg.sv
// rtl/mnist_pkg.sv - shared constants and state encoding for the MNIST frame host
package mnist_pkg;

    localparam int N_PIX = 784;
    localparam int PIX_W = 8;
    localparam int IMG_W = N_PIX * PIX_W;
    localparam int CNT_W = 10;

    localparam logic [3:0] ERR_DIGIT = 4'hF;

    typedef enum logic [2:0] {
        FILL,
        DRAIN,
        LAUNCH,
        WAIT,
        RESP
    } state_t;

endpackage

// File: rtl/img_frame_buf.sv
// rtl/img_frame_buf.sv - indexed pixel register file exposed as a flat image bus
module img_frame_buf
    import mnist_pkg::*;
(
    input  logic             clk,
    input  logic             clr,
    input  logic             wr_en,
    input  logic [CNT_W-1:0] wr_idx,
    input  logic [PIX_W-1:0] wr_data,
    output logic [IMG_W-1:0] img_data
);

    always_ff @(posedge clk) begin
        if (clr) begin
            img_data <= '0;
        end else if (wr_en && (wr_idx < CNT_W'(N_PIX))) begin
            img_data[wr_idx*PIX_W +: PIX_W] <= wr_data;
        end
    end

endmodule

// File: rtl/mnist_frame_host.sv
// rtl/mnist_frame_host.sv - frames a pixel stream into the accelerator and returns its digit
module mnist_frame_host
    import mnist_pkg::*;
#(
    parameter int TIMEOUT = 4095
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [PIX_W-1:0] s_data,
    input  logic             s_last,
    output logic [IMG_W-1:0] acc_img_data,
    output logic             acc_start,
    input  logic             acc_done,
    input  logic [3:0]       acc_pred,
    output logic             r_valid,
    input  logic             r_ready,
    output logic [3:0]       r_digit,
    output logic             r_err,
    output logic             busy
);

    localparam int WAIT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_PIX - 1);

    state_t            state;
    logic [CNT_W-1:0]  pix_cnt;
    logic [WAIT_W-1:0] wait_cnt;
    logic              done_q;
    logic              accept;
    logic              buf_wr;

    assign accept = s_valid && s_ready;
    assign buf_wr = accept && (state == FILL);

    img_frame_buf u_buf (
        .clk      (clk),
        .clr      (rst),
        .wr_en    (buf_wr),
        .wr_idx   (pix_cnt),
        .wr_data  (s_data),
        .img_data (acc_img_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= FILL;
            pix_cnt   <= '0;
            wait_cnt  <= '0;
            done_q    <= 1'b0;
            s_ready   <= 1'b1;
            acc_start <= 1'b0;
            r_valid   <= 1'b0;
            r_digit   <= 4'd0;
            r_err     <= 1'b0;
            busy      <= 1'b0;
        end else begin
            done_q    <= acc_done;
            acc_start <= 1'b0;
            case (state)
                FILL: begin
                    if (accept) begin
                        busy    <= 1'b1;
                        pix_cnt <= pix_cnt + 1'b1;
                        if (s_last && (pix_cnt == LAST_IDX)) begin
                            state     <= LAUNCH;
                            s_ready   <= 1'b0;
                            acc_start <= 1'b1;
                        end else if (s_last) begin
                            state   <= RESP;
                            s_ready <= 1'b0;
                            r_valid <= 1'b1;
                            r_err   <= 1'b1;
                            r_digit <= ERR_DIGIT;
                        end else if (pix_cnt == LAST_IDX) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (accept && s_last) begin
                        state   <= RESP;
                        s_ready <= 1'b0;
                        r_valid <= 1'b1;
                        r_err   <= 1'b1;
                        r_digit <= ERR_DIGIT;
                    end
                end
                LAUNCH: begin
                    state    <= WAIT;
                    wait_cnt <= '0;
                end
                WAIT: begin
                    // Only a fresh rising edge counts; a done left high by a prior run is ignored.
                    if (acc_done && !done_q) begin
                        state   <= RESP;
                        r_valid <= 1'b1;
                        r_err   <= 1'b0;
                        r_digit <= acc_pred;
                    end else if (wait_cnt == WAIT_W'(TIMEOUT)) begin
                        state   <= RESP;
                        r_valid <= 1'b1;
                        r_err   <= 1'b1;
                        r_digit <= ERR_DIGIT;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                RESP: begin
                    if (r_ready) begin
                        state   <= FILL;
                        r_valid <= 1'b0;
                        pix_cnt <= '0;
                        s_ready <= 1'b1;
                        busy    <= 1'b0;
                    end
                end
                default: begin
                    state <= FILL;
                end
            endcase
        end
    end

endmodule
